// File: rtl/lrf_pkg.sv
// Shared defaults and state encoding for the LRF AXI-Stream kernel shell.
package lrf_pkg;

    localparam int unsigned LRF_PIXEL_WIDTH     = 8;
    localparam int unsigned LRF_PIXELS_PER_BEAT = 16;
    localparam int unsigned LRF_BEATS_PER_FRAME = 16384;
    localparam int unsigned LRF_PIPE_LATENCY    = 9;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2
    } lrf_state_e;

endpackage

// File: rtl/lrf_axis_kernel_shell.sv
// Frame-aware AXI-Stream wrapper around an external fixed-latency kernel:
// steps the kernel, flushes its pipeline at frame end and re-frames the output.
module lrf_axis_kernel_shell
    import lrf_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
    parameter int unsigned PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
    parameter int unsigned BEATS_PER_FRAME = LRF_BEATS_PER_FRAME,
    parameter int unsigned PIPE_LATENCY    = LRF_PIPE_LATENCY
) (
    input  logic                                   s_axis_aclk,
    input  logic                                   s_axis_aresetn,
    input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] m_axis_tdata,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic                                   k_en,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] k_din,
    input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] k_dout,
    output logic [15:0]                            frame_cnt,
    output logic                                   err_early_tlast,
    output logic                                   err_missing_tlast
);

    localparam int unsigned WORD_WIDTH = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int unsigned CNT_W      = $clog2(BEATS_PER_FRAME + PIPE_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(PIPE_LATENCY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    lrf_state_e            r_state;
    logic [CNT_W-1:0]      r_in_cnt;
    logic [CNT_W-1:0]      r_adv_cnt;
    logic [CNT_W-1:0]      r_out_cnt;
    logic [CNT_W-1:0]      r_frame_len;
    logic [WORD_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [15:0]           r_frame_cnt;
    logic                  r_err_early;
    logic                  r_err_missing;

    logic w_out_free;
    logic w_advance;
    logic w_accept;
    logic w_load;
    logic w_out_take;
    logic w_in_at_max;
    logic w_last_adv;
    logic w_frame_done;

    // Handshake gating is also held off during reset so nothing is stepped or accepted.
    assign w_out_free    = ~r_m_tvalid | m_axis_tready;
    assign w_advance     = s_axis_aresetn & w_out_free &
                           (((r_state == ST_STREAM) & s_axis_tvalid) | (r_state == ST_FLUSH));
    assign s_axis_tready = s_axis_aresetn & (r_state == ST_STREAM) & w_out_free;
    assign w_accept      = s_axis_tready & s_axis_tvalid;

    assign k_en  = w_advance;
    assign k_din = (r_state == ST_STREAM) ? s_axis_tdata : '0;

    // Kernel output is meaningful only once the pipe has been primed with PIPE_LATENCY steps.
    assign w_load       = w_advance & (r_adv_cnt >= LAT);
    assign w_out_take   = r_m_tvalid & m_axis_tready;
    assign w_in_at_max  = (r_in_cnt == LAST_IN);
    assign w_last_adv   = (r_state == ST_FLUSH) & (r_adv_cnt == r_frame_len + LAT - ONE);
    assign w_frame_done = (r_state == ST_DRAIN) & w_out_take & (r_out_cnt == r_frame_len - ONE);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state       <= ST_STREAM;
            r_in_cnt      <= '0;
            r_adv_cnt     <= '0;
            r_out_cnt     <= '0;
            r_frame_len   <= '0;
            r_m_tdata     <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            if (w_load) begin
                r_m_tdata  <= k_dout;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_last_adv;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end

            if (w_out_take) begin
                r_out_cnt <= r_out_cnt + ONE;
            end
            if (w_advance) begin
                r_adv_cnt <= r_adv_cnt + ONE;
            end

            case (r_state)
                ST_STREAM: begin
                    if (w_accept) begin
                        r_in_cnt <= r_in_cnt + ONE;
                        if (s_axis_tlast | w_in_at_max) begin
                            r_frame_len <= r_in_cnt + ONE;
                            r_state     <= ST_FLUSH;
                        end
                        if (s_axis_tlast & ~w_in_at_max) begin
                            r_err_early <= 1'b1;
                        end
                        if (~s_axis_tlast & w_in_at_max) begin
                            r_err_missing <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_advance & w_last_adv) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Frame closes when its final output beat is taken downstream.
                    if (w_frame_done) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_in_cnt    <= '0;
                        r_adv_cnt   <= '0;
                        r_out_cnt   <= '0;
                        r_state     <= ST_STREAM;
                    end
                end
                default: begin
                    r_state <= ST_STREAM;
                end
            endcase
        end
    end

    assign m_axis_tdata      = r_m_tdata;
    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tlast      = r_m_tlast;
    assign frame_cnt         = r_frame_cnt;
    assign err_early_tlast   = r_err_early;
    assign err_missing_tlast = r_err_missing;

endmodule

// File: tb/tb_lrf_axis_kernel_shell.sv
// Directed bench for lrf_axis_kernel_shell with a 3-deep shift-register kernel model.
module tb_lrf_axis_kernel_shell;

    localparam int unsigned PW  = 8;
    localparam int unsigned PPB = 16;
    localparam int unsigned BPF = 8;
    localparam int unsigned PL  = 3;
    localparam int unsigned WW  = PW * PPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [WW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_ready = 1'b0;
    logic          k_en;
    logic [WW-1:0] k_din;
    logic [WW-1:0] k_dout;
    logic [15:0]   frame_cnt;
    logic          err_e;
    logic          err_m;

    logic [WW-1:0] kr [PL];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [WW-1:0] rx_data [$];
    bit            rx_last [$];
    int            rx_cyc  [$];
    int            acc_cyc [$];
    int            stall_viol = 0;
    bit            prev_stall = 1'b0;
    logic [WW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    lrf_axis_kernel_shell #(
        .PIXEL_WIDTH     (PW),
        .PIXELS_PER_BEAT (PPB),
        .BEATS_PER_FRAME (BPF),
        .PIPE_LATENCY    (PL)
    ) dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rst_n),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tlast      (m_tlast),
        .m_axis_tready     (m_ready),
        .k_en              (k_en),
        .k_din             (k_din),
        .k_dout            (k_dout),
        .frame_cnt         (frame_cnt),
        .err_early_tlast   (err_e),
        .err_missing_tlast (err_m)
    );

    // Kernel model: PL-deep shift register stepped by k_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PL; i++) kr[i] <= '0;
        end else if (k_en) begin
            kr[0] <= k_din;
            for (int i = 1; i < PL; i++) kr[i] <= kr[i-1];
        end
    end
    assign k_dout = kr[PL-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sampled mid-cycle, where inputs and registered outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) stall_viol++;
            if (m_tvalid && m_ready) begin
                rx_data.push_back(m_tdata);
                rx_last.push_back(m_tlast);
                rx_cyc.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_ready;
            prev_data  = m_tdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        acc_cyc.delete();
    endtask

    // Sends n beats valued base+1..base+n; tlast on last_idx (-1 for none).
    task automatic send_frame(input int n, input int last_idx, input int base, input int vprob);
        bit done;
        int guard;
        for (int i = 0; i < n; i++) begin
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                s_tvalid = ($urandom_range(99) < vprob);
                s_tdata  = WW'(base + i + 1);
                s_tlast  = (i == last_idx);
                @(negedge clk);
                if (s_tvalid && s_tready) begin
                    done = 1'b1;
                    acc_cyc.push_back(cyc);
                end
                @(posedge clk);
                #1;
                guard++;
                if (!done && guard > 400) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL send_timeout beat %0d: accepted 0 required 1", i);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Waits (bounded) for n outputs, then lingers so any surplus beat would be logged.
    task automatic wait_outputs(input int n);
        int k;
        k = 0;
        while (rx_data.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_tvalid = 1'b1;
        m_ready  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
        n_cmp++; if (m_tdata !== '0) begin n_bad++; $display("FAIL rst_m_tdata: got %0h expected 0", m_tdata); end
        n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
        n_cmp++; if (k_en !== 1'b0) begin n_bad++; $display("FAIL rst_k_en: got %b expected 0", k_en); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
        n_cmp++; if ({err_e, err_m} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b expected 00", {err_e, err_m}); end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous();
        clear_logs();
        m_ready = 1'b1;
        send_frame(8, 7, 0, 100);
        wait_outputs(8);
        n_cmp++; if (rx_data.size() != 8) begin n_bad++; $display("FAIL cont_count: got %0d expected 8", rx_data.size()); end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(i + 1)) begin n_bad++; $display("FAIL cont_data[%0d]: got %0h expected %0h", i, rx_data[i], i + 1); end
            n_cmp++; if (rx_last[i] !== (i == 7)) begin n_bad++; $display("FAIL cont_last[%0d]: got %b expected %b", i, rx_last[i], i == 7); end
        end
        if (rx_cyc.size() >= 8 && acc_cyc.size() >= 1) begin
            n_cmp++; if (rx_cyc[0] - acc_cyc[0] != PL + 1) begin n_bad++; $display("FAIL cont_latency: got %0d expected %0d", rx_cyc[0] - acc_cyc[0], PL + 1); end
            n_cmp++; if (rx_cyc[7] - rx_cyc[0] != 7) begin n_bad++; $display("FAIL cont_rate: got %0d expected 7", rx_cyc[7] - rx_cyc[0]); end
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL cont_frame_cnt: got %0d expected 1", frame_cnt); end
        n_cmp++; if ({err_e, err_m} !== 2'b00) begin n_bad++; $display("FAIL cont_err: got %b expected 00", {err_e, err_m}); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        m_ready = 1'b1;
        send_frame(8, 7, 32'h10, 100);
        send_frame(8, 7, 32'h20, 100);
        wait_outputs(16);
        n_cmp++; if (rx_data.size() != 16) begin n_bad++; $display("FAIL b2b_count: got %0d expected 16", rx_data.size()); end
        for (int i = 0; i < 16 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h10 * (i / 8 + 1) + i % 8 + 1)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h10 * (i / 8 + 1) + i % 8 + 1); end
            n_cmp++; if (rx_last[i] !== (i % 8 == 7)) begin n_bad++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, rx_last[i], i % 8 == 7); end
        end
        n_cmp++; if (acc_cyc.size() != 16) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 16", acc_cyc.size()); end
        if (acc_cyc.size() >= 9) begin
            n_cmp++; if (acc_cyc[8] - acc_cyc[7] - 1 != PL + 1) begin n_bad++; $display("FAIL b2b_idle: got %0d expected %0d", acc_cyc[8] - acc_cyc[7] - 1, PL + 1); end
        end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_backpressure();
        clear_logs();
        stall_viol = 0;
        fork
            begin
                send_frame(8, 7, 32'h50, 50);
                send_frame(8, 7, 32'h60, 50);
                send_frame(8, 7, 32'h70, 50);
            end
            begin
                for (int k = 0; k < 6000 && rx_data.size() < 24; k++) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(1));
                end
                m_ready = 1'b1;
            end
        join
        wait_outputs(24);
        n_cmp++; if (rx_data.size() != 24) begin n_bad++; $display("FAIL bp_count: got %0d expected 24", rx_data.size()); end
        for (int i = 0; i < 24 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h50 + 32'h10 * (i / 8) + i % 8 + 1)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h50 + 32'h10 * (i / 8) + i % 8 + 1); end
            n_cmp++; if (rx_last[i] !== (i % 8 == 7)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b expected %b", i, rx_last[i], i % 8 == 7); end
        end
        n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
        n_cmp++; if (frame_cnt !== 16'd6) begin n_bad++; $display("FAIL bp_frame_cnt: got %0d expected 6", frame_cnt); end
    endtask

    task automatic test_early_tlast();
        clear_logs();
        m_ready = 1'b1;
        send_frame(5, 4, 32'h30, 100);
        wait_outputs(5);
        n_cmp++; if (rx_data.size() != 5) begin n_bad++; $display("FAIL early_count: got %0d expected 5", rx_data.size()); end
        for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h31 + i)) begin n_bad++; $display("FAIL early_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h31 + i); end
            n_cmp++; if (rx_last[i] !== (i == 4)) begin n_bad++; $display("FAIL early_last[%0d]: got %b expected %b", i, rx_last[i], i == 4); end
        end
        n_cmp++; if (err_e !== 1'b1) begin n_bad++; $display("FAIL early_flag: got %b expected 1", err_e); end
        n_cmp++; if (err_m !== 1'b0) begin n_bad++; $display("FAIL early_missing_flag: got %b expected 0", err_m); end
        n_cmp++; if (frame_cnt !== 16'd7) begin n_bad++; $display("FAIL early_frame_cnt: got %0d expected 7", frame_cnt); end
        clear_logs();
        send_frame(8, 7, 32'h38, 100);
        wait_outputs(8);
        n_cmp++; if (rx_data.size() != 8) begin n_bad++; $display("FAIL early_next_count: got %0d expected 8", rx_data.size()); end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h39 + i)) begin n_bad++; $display("FAIL early_next_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h39 + i); end
            n_cmp++; if (rx_last[i] !== (i == 7)) begin n_bad++; $display("FAIL early_next_last[%0d]: got %b expected %b", i, rx_last[i], i == 7); end
        end
        n_cmp++; if (frame_cnt !== 16'd8) begin n_bad++; $display("FAIL early_next_frame_cnt: got %0d expected 8", frame_cnt); end
    endtask

    task automatic test_missing_tlast();
        clear_logs();
        m_ready = 1'b1;
        send_frame(8, -1, 32'h40, 100);
        wait_outputs(8);
        n_cmp++; if (rx_data.size() != 8) begin n_bad++; $display("FAIL miss_count: got %0d expected 8", rx_data.size()); end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h41 + i)) begin n_bad++; $display("FAIL miss_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h41 + i); end
            n_cmp++; if (rx_last[i] !== (i == 7)) begin n_bad++; $display("FAIL miss_last[%0d]: got %b expected %b", i, rx_last[i], i == 7); end
        end
        n_cmp++; if (err_m !== 1'b1) begin n_bad++; $display("FAIL miss_flag: got %b expected 1", err_m); end
        n_cmp++; if (frame_cnt !== 16'd9) begin n_bad++; $display("FAIL miss_frame_cnt: got %0d expected 9", frame_cnt); end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        m_ready = 1'b0;
        send_frame(4, -1, 32'h80, 100);
        @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_valid: got %b expected 1", m_tvalid); end
        n_cmp++; if (m_tdata !== WW'(32'h81)) begin n_bad++; $display("FAIL mrst_pre_data: got %0h expected 81", m_tdata); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b expected 0", m_tvalid); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_frame_cnt: got %0d expected 0", frame_cnt); end
        n_cmp++; if ({err_e, err_m} !== 2'b00) begin n_bad++; $display("FAIL mrst_err: got %b expected 00", {err_e, err_m}); end
        n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL mrst_s_tready: got %b expected 0", s_tready); end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        send_frame(8, 7, 32'h90, 100);
        wait_outputs(8);
        n_cmp++; if (rx_data.size() != 8) begin n_bad++; $display("FAIL mrst_count: got %0d expected 8", rx_data.size()); end
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            n_cmp++; if (rx_data[i] !== WW'(32'h91 + i)) begin n_bad++; $display("FAIL mrst_data[%0d]: got %0h expected %0h", i, rx_data[i], 32'h91 + i); end
            n_cmp++; if (rx_last[i] !== (i == 7)) begin n_bad++; $display("FAIL mrst_last[%0d]: got %b expected %b", i, rx_last[i], i == 7); end
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL mrst_frame_cnt_after: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_back_to_back();
        test_backpressure();
        test_early_tlast();
        test_missing_tlast();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lrf_axis_kernel_shell.md
LRF_AXIS_KERNEL_SHELL -- requirements
Module: lrf_axis_kernel_shell

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter PIXELS_PER_BEAT, default 16, pixels per stream word; WORD_WIDTH = PIXEL_WIDTH*PIXELS_PER_BEAT.
REQ-003 SHALL have parameter BEATS_PER_FRAME, default 16384, nominal beats per frame (512x512 at 16 px/beat).
REQ-004 SHALL have parameter PIPE_LATENCY, default 9, kernel advances from input beat to its result (range 1..63).
REQ-005 SHALL have ports, in this order: s_axis_aclk in 1, the single clock; s_axis_aresetn in 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_axis_tdata in WORD_WIDTH, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_tready out 1: input stream.
REQ-007 SHALL have ports m_axis_tdata out WORD_WIDTH, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_tready in 1: output stream.
REQ-008 SHALL have ports k_en out 1 (kernel step), k_din out WORD_WIDTH, and k_dout in WORD_WIDTH, which connect to an external CONV_GAUSS/CONV_SOBEL-style kernel.
REQ-009 SHALL have ports frame_cnt out 16, the count of completed frames, and err_early_tlast out 1 and err_missing_tlast out 1, which are sticky error flags.

Function
REQ-010 SHALL define advance = ((state==STREAM & s_axis_tvalid) | state==FLUSH) & (~m_axis_tvalid | m_axis_tready); k_en = advance.
REQ-011 SHALL drive s_axis_tready = (state==STREAM) & (~m_axis_tvalid | m_axis_tready).
REQ-012 SHALL drive k_din = s_axis_tdata in STREAM and all-zero in FLUSH.
REQ-013 SHALL keep adv_cnt, the advances this frame, and on an advance with adv_cnt >= PIPE_LATENCY load m_axis_tdata <= k_dout and set m_axis_tvalid; otherwise clear m_axis_tvalid when m_axis_tready is high.
REQ-014 SHALL keep m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid & ~m_axis_tready.
REQ-015 SHALL use states STREAM, FLUSH and DRAIN.
REQ-016 SHALL, in STREAM, count accepted beats in in_cnt.
REQ-017 SHALL, on accepting a beat with s_axis_tlast high or in_cnt == BEATS_PER_FRAME-1, latch frame_len = in_cnt+1 and go to FLUSH.
REQ-018 SHALL, on an accepted beat with s_axis_tlast high and in_cnt < BEATS_PER_FRAME-1, set err_early_tlast; the frame ends there.
REQ-019 SHALL, on an accepted beat with in_cnt == BEATS_PER_FRAME-1 and s_axis_tlast low, set err_missing_tlast; the frame still ends.
REQ-020 SHALL, in FLUSH, issue exactly PIPE_LATENCY advances with zero data, then go to DRAIN.
REQ-021 SHALL, in DRAIN, wait until the output beat with out_cnt == frame_len-1 is accepted, then increment frame_cnt (wrapping at 2^16), clear in_cnt/adv_cnt/out_cnt and return to STREAM.
REQ-022 SHALL assert m_axis_tlast exactly while m_axis_tvalid is high and the held beat is output index frame_len-1.
REQ-023 SHALL emit exactly frame_len output beats per frame, never more or fewer, for any tvalid/tready pattern.
REQ-024 SHALL have a minimum latency from the accepted input beat i to its output beat becoming valid of PIPE_LATENCY+1 cycles under continuous flow.
REQ-025 SHALL sustain 1 beat/cycle with tvalid=tready=1 continuously; the only bubbles are PIPE_LATENCY FLUSH cycles plus 1 DRAIN cycle per frame.
REQ-026 SHALL size counters to $clog2(BEATS_PER_FRAME+PIPE_LATENCY+1) bits; counters SHALL NOT wrap within a frame.

Reset
REQ-027 SHALL, while s_axis_aresetn is low, asynchronously force state=STREAM, all counters 0, frame_len 0, m_axis_tvalid 0, m_axis_tdata 0, error flags 0, and hence k_en 0 and s_axis_tready 0.
REQ-028 SHALL, on reset asserted mid-frame, discard the partial frame; after release the first accepted beat is beat 0 of a new frame.

Structure
REQ-029 SHALL place PIXEL_WIDTH, PIXELS_PER_BEAT and BEATS_PER_FRAME defaults and the state enum in a shared package, lrf_pkg.
REQ-030 SHALL contain no sub-module; the kernel is instantiated beside the shell by the parent.

Verification (BEATS_PER_FRAME=8, PIPE_LATENCY=3, the kernel modelled as a 3-deep enabled shift register)
REQ-031 SHALL verify continuous flow: send 8 beats 0x01..0x08 with tlast on the 8th -> outputs 0x01..0x08, tlast on 0x08, first output 4 cycles after the first accept, frame_cnt=1.
REQ-032 SHALL verify backpressure: random 50% tready/tvalid over 3 frames -> 24 outputs in order, no duplicates or drops, tdata stable while stalled.
REQ-033 SHALL verify early tlast: tlast on beat 5 -> 5 outputs with tlast on the 5th, err_early_tlast=1, and the next frame normal.
REQ-034 SHALL verify missing tlast: 8 beats with no tlast -> 8 outputs with tlast on the 8th, err_missing_tlast=1.
REQ-035 SHALL verify mid-frame reset: reset after 4 accepted beats -> m_axis_tvalid=0 immediately, frame_cnt=0, and a following full frame outputs 8 correct beats.
REQ-036 SHALL verify back-to-back frames: tready held high with 2 frames queued -> exactly 4 idle input cycles between frames and frame_cnt=2.
